icache_direct: RTL and testbench

- Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller's IF request port.
- IF issues word fetches to this block instead of to the memory controller.
- Hits return in one cycle. Misses run a single 4-byte read through the memory controller, fill the line, then respond.
- A taken jump from EX aborts any outstanding request, consistent with the IF_ID and ID_EX flush.

---
 rtl/icache_direct_if.sv | 25 ++
 rtl/icache_direct.sv | 134 +++++++++++++
 tb/tb_icache_direct.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
// Bundle of the IF-side fetch handshake and the memory-controller read port
// that the instruction cache sits between.
interface icache_direct_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rdy;
    logic [31:0] if_ins;
    logic [1:0]  memctl_op;
    logic [1:0]  memctl_len;
    logic [31:0] memctl_addr;
    logic        memctl_rdy;
    logic [31:0] memctl_out;

    // Cache side: serves IF requests and drives the controller read port.
    modport slave (
        input  if_req, if_addr, memctl_rdy, memctl_out,
        output if_rdy, if_ins, memctl_op, memctl_len, memctl_addr
    );

    // Environment side: IF stage plus memory controller.
    modport master (
        output if_req, if_addr, memctl_rdy, memctl_out,
        input  if_rdy, if_ins, memctl_op, memctl_len, memctl_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between IF and the
// memory controller. Hits answer the next cycle; misses issue one 4-byte read
// and fill the line. A taken jump aborts whatever is outstanding.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | accepting fetches; hits answered, misses launch a read
// ST_FETCH | read outstanding at memctl_addr, waiting for memctl_rdy
module icache_direct #(
    parameter int INDEX_W = 6,
    parameter int ADDR_HI = 17
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic take_jmp,
    icache_direct_if.slave bus
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_HI - INDEX_W - 1;

    typedef enum logic {ST_IDLE, ST_FETCH} state_t;

    state_t             state_q, state_d;
    logic               if_rdy_q, if_rdy_d;
    logic [31:0]        if_ins_q, if_ins_d;
    logic [1:0]         op_q, op_d;
    logic [1:0]         len_q, len_d;
    logic [31:0]        addr_q, addr_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [TAG_W-1:0]   tag_d [LINES];
    logic [31:0]        data_q [LINES];
    logic [31:0]        data_d [LINES];

    logic [INDEX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic               req_cacheable, fill_cacheable, hit;
    logic               unused_addr_bits;

    assign req_idx        = bus.if_addr[INDEX_W+1:2];
    assign req_tag        = bus.if_addr[ADDR_HI:INDEX_W+2];
    // The top two tag bits both set is the I/O window, never cached.
    assign req_cacheable  = (bus.if_addr[ADDR_HI:ADDR_HI-1] != 2'b11);
    assign fill_idx       = addr_q[INDEX_W+1:2];
    assign fill_tag       = addr_q[ADDR_HI:INDEX_W+2];
    assign fill_cacheable = (addr_q[ADDR_HI:ADDR_HI-1] != 2'b11);
    assign hit            = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && req_cacheable;
    assign unused_addr_bits = ^bus.if_addr[1:0];

    assign bus.if_rdy      = if_rdy_q;
    assign bus.if_ins      = if_ins_q;
    assign bus.memctl_op   = op_q;
    assign bus.memctl_len  = len_q;
    assign bus.memctl_addr = addr_q;

    // Next-state, response and fill computation; everything holds while rdy_in is low.
    always_comb begin
        state_d  = state_q;
        if_rdy_d = if_rdy_q;
        if_ins_d = if_ins_q;
        op_d     = op_q;
        len_d    = len_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        if (rdy_in) begin
            if_rdy_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.if_req && !take_jmp) begin
                        if (hit) begin
                            if_rdy_d = 1'b1;
                            if_ins_d = data_q[req_idx];
                        end else begin
                            state_d = ST_FETCH;
                            op_d    = 2'b01;
                            len_d   = 2'b11;
                            addr_d  = {bus.if_addr[31:2], 2'b00};
                        end
                    end
                end
                ST_FETCH: begin
                    if (take_jmp) begin
                        // Controller drops its transaction on the same jump.
                        state_d = ST_IDLE;
                        op_d    = 2'b00;
                        len_d   = 2'b00;
                    end else if (bus.memctl_rdy) begin
                        if (fill_cacheable) begin
                            valid_d[fill_idx] = 1'b1;
                            tag_d[fill_idx]   = fill_tag;
                            data_d[fill_idx]  = bus.memctl_out;
                        end
                        if_rdy_d = 1'b1;
                        if_ins_d = bus.memctl_out;
                        state_d  = ST_IDLE;
                        op_d     = 2'b00;
                        len_d    = 2'b00;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control, response and valid-bit registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            if_rdy_q <= 1'b0;
            if_ins_q <= '0;
            op_q     <= 2'b00;
            len_q    <= 2'b00;
            addr_q   <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            if_rdy_q <= if_rdy_d;
            if_ins_q <= if_ins_d;
            op_q     <= op_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_in) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_icache_direct.sv
// Scenario bench for icache_direct: expected instructions are queued when a
// fetch is driven and checked by a monitor whenever if_rdy pulses.
module tb_icache_direct;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, take_jmp;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [31:0] exp_q [$];

    icache_direct_if bus ();

    icache_direct dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .take_jmp (take_jmp),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (!rst_in && rdy_in && bus.if_rdy === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_if_rdy: got if_ins=%h, no fetch outstanding", bus.if_ins);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.if_ins !== e) begin
                    n_fail++;
                    $display("FAIL if_ins: got %h want %h", bus.if_ins, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [31:0] data, input int lat);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        tick();
        n_cmp++;
        if (bus.memctl_op !== 2'b01 || bus.memctl_len !== 2'b11 || bus.memctl_addr !== addr || bus.if_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_issue: got op=%b len=%b addr=%h rdy=%b want op=01 len=11 addr=%h rdy=0",
                     bus.memctl_op, bus.memctl_len, bus.memctl_addr, bus.if_rdy, addr);
        end
        for (int i = 1; i < lat; i++) begin
            tick();
            n_cmp++;
            if (bus.memctl_op !== 2'b01 || bus.memctl_addr !== addr || bus.if_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_hold: got op=%b addr=%h rdy=%b want op=01 addr=%h rdy=0",
                         bus.memctl_op, bus.memctl_addr, bus.if_rdy, addr);
            end
        end
        bus.memctl_rdy = 1'b1;
        bus.memctl_out = data;
        exp_q.push_back(data);
        tick();
        bus.memctl_rdy = 1'b0;
        bus.if_req     = 1'b0;
        n_cmp++;
        if (bus.if_rdy !== 1'b1 || bus.memctl_op !== 2'b00) begin
            n_fail++;
            $display("FAIL miss_done: got rdy=%b op=%b want rdy=1 op=00", bus.if_rdy, bus.memctl_op);
        end
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic [31:0] data);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        exp_q.push_back(data);
        tick();
        bus.if_req = 1'b0;
        n_cmp++;
        if (bus.if_rdy !== 1'b1 || bus.memctl_op !== 2'b00) begin
            n_fail++;
            $display("FAIL hit: addr=%h got rdy=%b op=%b want rdy=1 op=00", addr, bus.if_rdy, bus.memctl_op);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; take_jmp = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.memctl_rdy = 1'b0; bus.memctl_out = '0;
        tick();
        tick();
        n_cmp++;
        if (bus.if_rdy !== 1'b0 || bus.if_ins !== 32'h0 || bus.memctl_op !== 2'b00 ||
            bus.memctl_len !== 2'b00 || bus.memctl_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b ins=%h op=%b len=%b addr=%h want all zero",
                     bus.if_rdy, bus.if_ins, bus.memctl_op, bus.memctl_len, bus.memctl_addr);
        end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_cold_miss_hit();
        do_miss(32'h0000_0000, 32'h0000_0513, 4);
        tick();
        do_hit(32'h0000_0000, 32'h0000_0513);
        tick();
        n_cmp++;
        if (bus.if_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_rdy: got %b want 0", bus.if_rdy);
        end
    endtask

    task automatic test_back_to_back();
        do_miss(32'h0000_0004, 32'h1111_0004, 2);
        do_miss(32'h0000_0008, 32'h2222_0008, 3);
        bus.if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] d;
            case (i)
                0: d = 32'h0000_0513;
                1: d = 32'h1111_0004;
                default: d = 32'h2222_0008;
            endcase
            bus.if_addr = 32'(i * 4);
            exp_q.push_back(d);
            tick();
            n_cmp++;
            if (bus.if_rdy !== 1'b1 || bus.memctl_op !== 2'b00) begin
                n_fail++;
                $display("FAIL b2b_rdy[%0d]: got rdy=%b op=%b want rdy=1 op=00", i, bus.if_rdy, bus.memctl_op);
            end
        end
        bus.if_req = 1'b0;
        tick();
        n_cmp++;
        if (bus.if_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got rdy=%b want 0", bus.if_rdy);
        end
    endtask

    task automatic test_conflict();
        do_miss(32'h0000_0100, 32'hAAAA_0100, 2);
        do_hit(32'h0000_0100, 32'hAAAA_0100);
        do_miss(32'h0000_0200, 32'hBBBB_0200, 3);
        do_miss(32'h0000_0100, 32'hCCCC_0100, 2);
        do_hit(32'h0000_0100, 32'hCCCC_0100);
    endtask

    task automatic test_jump_abort();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0040;
        tick();
        n_cmp++;
        if (bus.memctl_op !== 2'b01) begin
            n_fail++;
            $display("FAIL jmp_issue: got op=%b want 01", bus.memctl_op);
        end
        tick();
        bus.if_req     = 1'b0;
        take_jmp       = 1'b1;
        bus.memctl_rdy = 1'b1;
        bus.memctl_out = 32'hDEAD_0040;
        tick();
        take_jmp       = 1'b0;
        bus.memctl_rdy = 1'b0;
        n_cmp++;
        if (bus.if_rdy !== 1'b0 || bus.memctl_op !== 2'b00) begin
            n_fail++;
            $display("FAIL jmp_abort: got rdy=%b op=%b want rdy=0 op=00", bus.if_rdy, bus.memctl_op);
        end
        do_miss(32'h0000_0040, 32'h4444_0040, 2);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0004;
        take_jmp    = 1'b1;
        tick();
        bus.if_req = 1'b0;
        take_jmp   = 1'b0;
        n_cmp++;
        if (bus.if_rdy !== 1'b0 || bus.memctl_op !== 2'b00) begin
            n_fail++;
            $display("FAIL jmp_idle_drop: got rdy=%b op=%b want rdy=0 op=00", bus.if_rdy, bus.memctl_op);
        end
        do_hit(32'h0000_0004, 32'h1111_0004);
    endtask

    task automatic test_rdy_freeze();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0080;
        tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.memctl_rdy = (i != 1);
            bus.memctl_out = 32'hBAD0_0000 | 32'(i);
            take_jmp       = (i == 1);
            tick();
            n_cmp++;
            if (bus.memctl_op !== 2'b01 || bus.memctl_addr !== 32'h0000_0080 || bus.if_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze[%0d]: got op=%b addr=%h rdy=%b want op=01 addr=00000080 rdy=0",
                         i, bus.memctl_op, bus.memctl_addr, bus.if_rdy);
            end
        end
        take_jmp       = 1'b0;
        bus.memctl_rdy = 1'b0;
        rdy_in         = 1'b1;
        tick();
        n_cmp++;
        if (bus.memctl_op !== 2'b01 || bus.if_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL thaw: got op=%b rdy=%b want op=01 rdy=0", bus.memctl_op, bus.if_rdy);
        end
        bus.memctl_rdy = 1'b1;
        bus.memctl_out = 32'h8888_0080;
        exp_q.push_back(32'h8888_0080);
        tick();
        bus.memctl_rdy = 1'b0;
        bus.if_req     = 1'b0;
        n_cmp++;
        if (bus.if_rdy !== 1'b1 || bus.memctl_op !== 2'b00) begin
            n_fail++;
            $display("FAIL thaw_done: got rdy=%b op=%b want rdy=1 op=00", bus.if_rdy, bus.memctl_op);
        end
        do_hit(32'h0000_0080, 32'h8888_0080);
    endtask

    task automatic test_uncacheable_and_reset();
        do_miss(32'h0003_0000, 32'h0300_0001, 2);
        do_miss(32'h0003_0000, 32'h0300_0002, 3);
        do_miss(32'h0000_0000, 32'h0000_0513, 2);
        do_hit(32'h0000_0000, 32'h0000_0513);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_000C;
        tick();
        rst_in = 1'b1;
        tick();
        rst_in     = 1'b0;
        bus.if_req = 1'b0;
        n_cmp++;
        if (bus.memctl_op !== 2'b00 || bus.if_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: got op=%b rdy=%b want op=00 rdy=0", bus.memctl_op, bus.if_rdy);
        end
        tick();
        do_miss(32'h0000_0000, 32'h0000_0513, 2);
    endtask

    initial begin
        test_reset();
        test_cold_miss_hit();
        test_back_to_back();
        test_conflict();
        test_jump_abort();
        test_rdy_freeze();
        test_uncacheable_and_reset();
        tick();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_if_rdy: got %0d responses outstanding want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
